dfp_addsub_iter: RTL and testbench

Parametrised, iterative decimal floating-point add/subtract core that aligns operands one BCD digit per cycle. It replaces a fixed-width, fully pipelined adder where area matters more than throughput. It accepts unpacked operands over a valid/ready handshake and emits an unnormalised, unrounded result (carry digit, N digits, guard digit, sticky) for the existing normalise/round stages. Unlike the fixed pipeline, it resolves true magnitude order after subtraction, so unnormalised operands produce a correct sign.

---
 rtl/dfp_addsub_iter_pkg.sv | 27 ++
 rtl/BCDAddN.sv | 30 +++
 rtl/BCDSubN.sv | 32 +++
 rtl/dfp_addsub_iter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dfp_addsub_iter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfp_addsub_iter_pkg.sv
// Shared state encoding, rounding-mode constant and default quiet-NaN
// significand for the iterative decimal floating-point add/subtract core.
package dfp_addsub_iter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_ALIGN,
        S_ADD,
        S_NEG,
        S_DONE
    } dfp_as_state_t;

    localparam logic [2:0] RM_RDN = 3'd3;

    // Widest significand field the NaN helper can build (N up to 64).
    localparam int SIGW_MAX = 4 * (64 + 2);

    // {carry, N digits, guard} with a single 9 in the significand MSD.
    function automatic logic [SIGW_MAX-1:0] qnan_sig(input int n);
        logic [SIGW_MAX-1:0] s;
        s = '0;
        s[4*n +: 4] = 4'h9;
        return s;
    endfunction

endpackage

// File: rtl/BCDAddN.sv
// Ripple-carry BCD adder over D digits; carry out of the top digit is
// dropped because callers keep a zero carry digit in both operands.
module BCDAddN #(
    parameter int D = 36
) (
    input  logic [4*D-1:0] a_i,
    input  logic [4*D-1:0] b_i,
    output logic [4*D-1:0] s_o
);

    logic       c;
    logic [4:0] t;

    always_comb begin
        c   = 1'b0;
        t   = '0;
        s_o = '0;
        for (int i = 0; i < D; i++) begin
            t = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, c};
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s_o[4*i +: 4] = t[3:0];
        end
    end

endmodule

// File: rtl/BCDSubN.sv
// Ripple-borrow BCD subtractor over D digits: d = a - b, with the final
// borrow flagging a negative (ten's-complement) result.
module BCDSubN #(
    parameter int D = 36
) (
    input  logic [4*D-1:0] a_i,
    input  logic [4*D-1:0] b_i,
    output logic [4*D-1:0] d_o,
    output logic           bo_o
);

    logic       br;
    logic [4:0] t;

    always_comb begin
        br  = 1'b0;
        t   = '0;
        d_o = '0;
        for (int i = 0; i < D; i++) begin
            t = {1'b0, a_i[4*i +: 4]} - {1'b0, b_i[4*i +: 4]} - {4'b0, br};
            if (t[4]) begin
                t  = t + 5'd10;
                br = 1'b1;
            end else begin
                br = 1'b0;
            end
            d_o[4*i +: 4] = t[3:0];
        end
        bo_o = br;
    end

endmodule

// File: rtl/dfp_addsub_iter.sv
// Iterative decimal FP add/subtract: aligns one BCD digit per cycle and
// emits an unnormalised {carry, N digits, guard} result plus sticky.
module dfp_addsub_iter
    import dfp_addsub_iter_pkg::*;
#(
    parameter int N  = 34,
    parameter int EW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [2:0]           rm,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 op,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic [EW-1:0]        a_exp,
    input  logic [EW-1:0]        b_exp,
    input  logic [N*4-1:0]       a_sig,
    input  logic [N*4-1:0]       b_sig,
    input  logic                 a_nan,
    input  logic                 b_nan,
    input  logic                 a_inf,
    input  logic                 b_inf,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_sign,
    output logic [EW-1:0]        o_exp,
    output logic [(N+2)*4-1:0]   o_sig,
    output logic                 o_sticky,
    output logic                 o_nan,
    output logic                 o_qnan,
    output logic                 o_inf
);

    localparam int W  = (N + 2) * 4;
    localparam int CW = $clog2(N + 2);

    dfp_as_state_t state_q, state_d;

    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [EW-1:0] ea_q, ea_d, eb_q, eb_d, ex_q, ex_d;
    logic          sa_q, sa_d, sb_q, sb_d, op_q, op_d;
    logic          an_q, an_d, bn_q, bn_d, ai_q, ai_d, bi_q, bi_d;
    logic [2:0]    rm_q, rm_d;
    logic          xs_q, xs_d, ys_q, ys_d;
    logic [CW-1:0] k_q, k_d;
    logic          st_q, st_d;

    logic          sign_q, sign_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [W-1:0]  sig_q, sig_d;
    logic          sticky_q, sticky_d;
    logic          nan_q, nan_d, qnan_q, qnan_d, inf_q, inf_d;

    logic          es, sbe, swap, fin, rsign, borrow;
    logic [EW-1:0] dexp;
    logic [CW-1:0] kk;
    logic [W-1:0]  sum, diff, sub_a, sub_b, res;

    assign es  = op_q ^ sa_q ^ sb_q;
    assign sbe = sb_q ^ op_q;

    // NEG reuses the single subtractor with its operands swapped.
    assign sub_a = (state_q == S_NEG) ? y_q : x_q;
    assign sub_b = (state_q == S_NEG) ? x_q : y_q;

    BCDAddN #(.D(N + 2)) u_add (
        .a_i (x_q),
        .b_i (y_q),
        .s_o (sum)
    );

    BCDSubN #(.D(N + 2)) u_sub (
        .a_i  (sub_a),
        .b_i  (sub_b),
        .d_o  (diff),
        .bo_o (borrow)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ex_d     = ex_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        op_d     = op_q;
        an_d     = an_q;
        bn_d     = bn_q;
        ai_d     = ai_q;
        bi_d     = bi_q;
        rm_d     = rm_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        k_d      = k_q;
        st_d     = st_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        sticky_d = sticky_q;
        nan_d    = nan_q;
        qnan_d   = qnan_q;
        inf_d    = inf_q;
        res      = '0;
        fin      = 1'b0;
        rsign    = xs_q;

        swap = eb_q > ea_q;
        dexp = swap ? (eb_q - ea_q) : (ea_q - eb_q);
        // Saturate: beyond N+1 digits the whole of Y lands in sticky anyway.
        kk   = (dexp > EW'(N + 1)) ? CW'(N + 1) : dexp[CW-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    x_d     = {4'h0, a_sig, 4'h0};
                    y_d     = {4'h0, b_sig, 4'h0};
                    ea_d    = a_exp;
                    eb_d    = b_exp;
                    sa_d    = a_sign;
                    sb_d    = b_sign;
                    op_d    = op;
                    an_d    = a_nan;
                    bn_d    = b_nan;
                    ai_d    = a_inf;
                    bi_d    = b_inf;
                    rm_d    = rm;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                sign_d   = 1'b0;
                exp_d    = '0;
                sig_d    = '0;
                sticky_d = 1'b0;
                nan_d    = 1'b0;
                qnan_d   = 1'b0;
                inf_d    = 1'b0;
                st_d     = 1'b0;
                if (an_q || bn_q) begin
                    nan_d   = 1'b1;
                    sig_d   = an_q ? x_q : y_q;
                    sign_d  = an_q ? sa_q : sb_q;
                    state_d = S_DONE;
                end else if (ai_q && bi_q && es) begin
                    qnan_d  = 1'b1;
                    sig_d   = W'(qnan_sig(N));
                    state_d = S_DONE;
                end else if (ai_q || bi_q) begin
                    inf_d   = 1'b1;
                    sign_d  = ai_q ? sa_q : sbe;
                    state_d = S_DONE;
                end else if (x_q == '0 && y_q == '0) begin
                    sign_d  = es ? (rm_q == RM_RDN) : sa_q;
                    state_d = S_DONE;
                end else begin
                    ex_d    = swap ? eb_q : ea_q;
                    x_d     = swap ? y_q : x_q;
                    y_d     = swap ? x_q : y_q;
                    xs_d    = swap ? sbe : sa_q;
                    ys_d    = swap ? sa_q : sbe;
                    k_d     = kk;
                    state_d = (kk == '0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                st_d = st_q | (y_q[3:0] != 4'h0);
                y_d  = y_q >> 4;
                k_d  = k_q - CW'(1);
                if (k_q == CW'(1)) state_d = S_ADD;
            end
            S_ADD: begin
                if (!es) begin
                    res = sum;
                    fin = 1'b1;
                end else if (borrow) begin
                    state_d = S_NEG;
                end else begin
                    res = diff;
                    fin = 1'b1;
                end
            end
            S_NEG: begin
                res   = diff;
                rsign = ys_q;
                fin   = 1'b1;
            end
            S_DONE: begin
                if (o_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d  = S_DONE;
            sig_d    = res;
            sticky_d = st_q;
            if (res == '0 && !st_q) begin
                exp_d  = '0;
                sign_d = es ? (rm_q == RM_RDN) : xs_q;
            end else begin
                exp_d  = ex_q;
                sign_d = rsign;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            ea_q     <= '0;
            eb_q     <= '0;
            ex_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            op_q     <= 1'b0;
            an_q     <= 1'b0;
            bn_q     <= 1'b0;
            ai_q     <= 1'b0;
            bi_q     <= 1'b0;
            rm_q     <= '0;
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            k_q      <= '0;
            st_q     <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            sticky_q <= 1'b0;
            nan_q    <= 1'b0;
            qnan_q   <= 1'b0;
            inf_q    <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ex_q     <= ex_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            op_q     <= op_d;
            an_q     <= an_d;
            bn_q     <= bn_d;
            ai_q     <= ai_d;
            bi_q     <= bi_d;
            rm_q     <= rm_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            k_q      <= k_d;
            st_q     <= st_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            sticky_q <= sticky_d;
            nan_q    <= nan_d;
            qnan_q   <= qnan_d;
            inf_q    <= inf_d;
        end
    end

    assign i_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_sign   = sign_q;
    assign o_exp    = exp_q;
    assign o_sig    = sig_q;
    assign o_sticky = sticky_q;
    assign o_nan    = nan_q;
    assign o_qnan   = qnan_q;
    assign o_inf    = inf_q;

endmodule

// File: tb/tb_dfp_addsub_iter.sv
// Scoreboard bench for dfp_addsub_iter at N=7, EW=8: directed operations,
// specials, back-pressure, clock-enable stalls and mid-operation reset.
module tb_dfp_addsub_iter;

    localparam int N  = 7;
    localparam int EW = 8;
    localparam int W  = (N + 2) * 4;

    logic          clk = 1'b0;
    logic          rst, ce;
    logic [2:0]    rm;
    logic          i_valid, i_ready, op;
    logic          a_sign, b_sign;
    logic [EW-1:0] a_exp, b_exp;
    logic [N*4-1:0] a_sig, b_sig;
    logic          a_nan, b_nan, a_inf, b_inf;
    logic          o_valid, o_ready, o_sign;
    logic [EW-1:0] o_exp;
    logic [W-1:0]  o_sig;
    logic          o_sticky, o_nan, o_qnan, o_inf;

    always #5 clk = ~clk;

    dfp_addsub_iter #(.N(N), .EW(EW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rm(rm),
        .i_valid(i_valid), .i_ready(i_ready), .op(op),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig),
        .a_nan(a_nan), .b_nan(b_nan), .a_inf(a_inf), .b_inf(b_inf),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig),
        .o_sticky(o_sticky), .o_nan(o_nan), .o_qnan(o_qnan), .o_inf(o_inf)
    );

    typedef struct {
        logic        op;
        logic        as;
        logic [7:0]  ae;
        logic [27:0] asg;
        logic        bs;
        logic [7:0]  be;
        logic [27:0] bsg;
        logic [3:0]  cls;
        logic [2:0]  rmv;
        logic [48:0] res;
        int          lat;
    } stim_t;

    typedef struct {
        logic [48:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [48:0] obs;

    function automatic logic [48:0] pk(input logic s, input logic [7:0] e,
                                       input logic [35:0] g, input logic st,
                                       input logic nan, input logic qn,
                                       input logic inf);
        return {s, e, g, st, nan, qn, inf};
    endfunction

    function automatic logic [48:0] now_out();
        return {o_sign, o_exp, o_sig, o_sticky, o_nan, o_qnan, o_inf};
    endfunction

    task automatic send(input stim_t s);
        int n;
        @(negedge clk);
        op = s.op;
        a_sign = s.as; a_exp = s.ae; a_sig = s.asg;
        b_sign = s.bs; b_exp = s.be; b_sig = s.bsg;
        {a_nan, b_nan, a_inf, b_inf} = s.cls;
        rm = s.rmv;
        i_valid = 1'b1;
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        sb.push_back('{s.res, s.lat});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
    endtask

    task automatic wait_out();
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        obs = now_out();
        if (o_valid && o_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; o_ready = 1'b1; i_valid = 1'b0;
        op = 0; rm = 0; a_sign = 0; b_sign = 0; a_exp = 0; b_exp = 0;
        a_sig = 0; b_sig = 0; a_nan = 0; b_nan = 0; a_inf = 0; b_inf = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({i_ready, o_valid, now_out()} !== {1'b1, 1'b0, 49'h0}) begin
            errors++;
            $display("FAIL reset got rdy=%b vld=%b out=%h want 1 0 0",
                     i_ready, o_valid, now_out());
        end
    endtask

    task automatic test_add();
        stim_t s[2];
        exp_t  e;
        s[0] = '{0, 0, 8'd5, 28'h1234000, 0, 8'd5, 28'h0005000, 4'b0000, 3'd0,
                 pk(0, 8'd5, {4'h0, 28'h1239000, 4'h0}, 0, 0, 0, 0), 3};
        s[1] = '{0, 0, 8'd2, 28'h9000000, 0, 8'd2, 28'h2000000, 4'b0000, 3'd0,
                 pk(0, 8'd2, {4'h1, 28'h1000000, 4'h0}, 0, 0, 0, 0), 3};
        for (int i = 0; i < 2; i++) begin
            send(s[i]);
            wait_out();
            e = sb.pop_front();
            checks++;
            if (obs !== e.res) begin
                errors++;
                $display("FAIL add[%0d] result got %h want %h", i, obs, e.res);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL add[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_align();
        stim_t s[3];
        exp_t  e;
        s[0] = '{0, 0, 8'd10, 28'h1000000, 0, 8'd7, 28'h5000000, 4'b0000, 3'd0,
                 pk(0, 8'd10, {4'h0, 28'h1005000, 4'h0}, 0, 0, 0, 0), 6};
        s[1] = '{1, 0, 8'd3, 28'h2000000, 0, 8'd4, 28'h5000000, 4'b0000, 3'd0,
                 pk(1, 8'd4, {4'h0, 28'h4800000, 4'h0}, 0, 0, 0, 0), 4};
        s[2] = '{0, 0, 8'd30, 28'h1000000, 0, 8'd10, 28'h0000001, 4'b0000, 3'd0,
                 pk(0, 8'd30, {4'h0, 28'h1000000, 4'h0}, 1, 0, 0, 0), 11};
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            wait_out();
            e = sb.pop_front();
            checks++;
            if (obs !== e.res) begin
                errors++;
                $display("FAIL align[%0d] result got %h want %h", i, obs, e.res);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL align[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_sub();
        stim_t s[3];
        exp_t  e;
        s[0] = '{1, 0, 8'd5, 28'h1000000, 0, 8'd5, 28'h3000000, 4'b0000, 3'd0,
                 pk(1, 8'd5, {4'h0, 28'h2000000, 4'h0}, 0, 0, 0, 0), 4};
        s[1] = '{1, 0, 8'd9, 28'h4200000, 0, 8'd9, 28'h4200000, 4'b0000, 3'd0,
                 pk(0, 8'd0, 36'h0, 0, 0, 0, 0), 3};
        s[2] = '{1, 0, 8'd9, 28'h4200000, 0, 8'd9, 28'h4200000, 4'b0000, 3'd3,
                 pk(1, 8'd0, 36'h0, 0, 0, 0, 0), 3};
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            wait_out();
            e = sb.pop_front();
            checks++;
            if (obs !== e.res) begin
                errors++;
                $display("FAIL sub[%0d] result got %h want %h", i, obs, e.res);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL sub[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_specials();
        stim_t s[4];
        exp_t  e;
        s[0] = '{1, 0, 8'd0, 28'h0, 0, 8'd0, 28'h0, 4'b0011, 3'd0,
                 pk(0, 8'd0, {4'h0, 28'h9000000, 4'h0}, 0, 0, 1, 0), 2};
        s[1] = '{1, 0, 8'd5, 28'h1000000, 0, 8'd0, 28'h0, 4'b0001, 3'd0,
                 pk(1, 8'd0, 36'h0, 0, 0, 0, 1), 2};
        s[2] = '{0, 0, 8'd5, 28'h1000000, 0, 8'd0, 28'h0000123, 4'b0100, 3'd0,
                 pk(0, 8'd0, {4'h0, 28'h0000123, 4'h0}, 0, 1, 0, 0), 2};
        s[3] = '{0, 1, 8'd4, 28'h0, 1, 8'd6, 28'h0, 4'b0000, 3'd0,
                 pk(1, 8'd0, 36'h0, 0, 0, 0, 0), 2};
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            wait_out();
            e = sb.pop_front();
            checks++;
            if (obs !== e.res) begin
                errors++;
                $display("FAIL special[%0d] result got %h want %h", i, obs, e.res);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL special[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t s;
        exp_t  e;
        s = '{0, 0, 8'd5, 28'h1234000, 0, 8'd5, 28'h0005000, 4'b0000, 3'd0,
              pk(0, 8'd5, {4'h0, 28'h1239000, 4'h0}, 0, 0, 0, 0), 3};
        o_ready = 1'b0;
        send(s);
        wait_out();
        e = sb.pop_front();
        checks++;
        if (obs !== e.res) begin
            errors++;
            $display("FAIL bp result got %h want %h", obs, e.res);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({o_valid, i_ready, now_out()} !== {1'b1, 1'b0, e.res}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b rdy=%b out=%h want 1 0 %h",
                         i, o_valid, i_ready, now_out(), e.res);
            end
        end
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, i_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", o_valid, i_ready);
        end
    endtask

    task automatic test_ce();
        stim_t s;
        exp_t  e;
        s = '{0, 0, 8'd10, 28'h1000000, 0, 8'd7, 28'h5000000, 4'b0000, 3'd0,
              pk(0, 8'd10, {4'h0, 28'h1005000, 4'h0}, 0, 0, 0, 0), 9};
        send(s);
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ce = 1'b1;
        lat = lat + 3;
        wait_out();
        e = sb.pop_front();
        checks++;
        if (obs !== e.res) begin
            errors++;
            $display("FAIL ce result got %h want %h", obs, e.res);
        end
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL ce latency got %0d want %0d", lat, e.lat);
        end
    endtask

    task automatic test_rst_mid();
        stim_t s;
        exp_t  e;
        int    seen;
        s = '{0, 0, 8'd30, 28'h1000000, 0, 8'd10, 28'h0000001, 4'b0000, 3'd0,
              pk(0, 8'd30, {4'h0, 28'h1000000, 4'h0}, 1, 0, 0, 0), 11};
        send(s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, i_ready, now_out()} !== {1'b0, 1'b1, 49'h0}) begin
            errors++;
            $display("FAIL rst_mid got vld=%b rdy=%b out=%h want 0 1 0",
                     o_valid, i_ready, now_out());
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_novalid got %0d valid cycles want 0", seen);
        end
        // The aborted operation never produces a result.
        void'(sb.pop_front());
        s = '{1, 0, 8'd5, 28'h1000000, 0, 8'd5, 28'h3000000, 4'b0000, 3'd0,
              pk(1, 8'd5, {4'h0, 28'h2000000, 4'h0}, 0, 0, 0, 0), 4};
        send(s);
        wait_out();
        e = sb.pop_front();
        checks++;
        if (obs !== e.res || lat != e.lat) begin
            errors++;
            $display("FAIL rst_recover got %h lat %0d want %h lat %0d",
                     obs, lat, e.res, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_align();
        test_sub();
        test_specials();
        test_backpressure();
        test_ce();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
